// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: frame field widths,
// the default sync marker and the parser state encoding.
package imem_loader_pkg;

   localparam int BYTE_W = 8;
   localparam int ADDR_W = 20;
   localparam int DATA_W = 16;
   localparam int LEN_W  = 16;

   localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_ADDR0   = 4'd1,
      ST_ADDR1   = 4'd2,
      ST_ADDR2   = 4'd3,
      ST_LEN0    = 4'd4,
      ST_LEN1    = 4'd5,
      ST_DATA_LO = 4'd6,
      ST_DATA_HI = 4'd7,
      ST_CSUM    = 4'd8
   } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte link plus instruction-memory write port and core control.
// master = host / memory side, slave = the loader.
interface imem_loader_if import imem_loader_pkg::*;;

   logic [BYTE_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic [ADDR_W-1:0] instruction_wr1;
   logic [DATA_W-1:0] instruction_wr1_data;
   logic              instruction_wr1_enable;
   logic              core_hold;
   logic              load_done;
   logic              load_error;

   modport master (
      output rx_data, rx_valid,
      input  rx_ready, instruction_wr1, instruction_wr1_data,
             instruction_wr1_enable, core_hold, load_done, load_error
   );

   modport slave (
      input  rx_data, rx_valid,
      output rx_ready, instruction_wr1, instruction_wr1_data,
             instruction_wr1_enable, core_hold, load_done, load_error
   );

endinterface

// File: rtl/imem_loader_timeout.sv
// Mid-frame idle counter: clears on any accepted byte or while stopped,
// flags expiry on the cycle it would reach TIMEOUT.
module loader_timeout #(
   parameter int TIMEOUT = 1024
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] count;

   // An accepted byte on the terminal cycle wins over expiry.
   assign expire = run && !clear && (count == CW'(TIMEOUT - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                      count <= '0;
      else if (clear || !run || expire) count <= '0;
      else                             count <= count + CW'(1);
   end

endmodule

// File: rtl/imem_loader.sv
// Framed program loader: parses SYNC/addr/len/data/checksum from the host
// byte stream, writes instruction memory and holds the core during a load.
module imem_loader import imem_loader_pkg::*; #(
   parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEF,
   parameter int                TIMEOUT   = 1024
) (
   input  logic         clock,
   input  logic         reset,
   imem_loader_if.slave bus
);

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [LEN_W-1:0]  remain;
   logic [BYTE_W-1:0] csum;
   logic [BYTE_W-1:0] d_lo;
   logic              expire;

   wire               acc = bus.rx_valid && bus.rx_ready;
   wire  [BYTE_W-1:0] d   = bus.rx_data;

   loader_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clock  (clock),
      .reset  (reset),
      .clear  (acc),
      .run    (state != ST_IDLE),
      .expire (expire)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state                      <= ST_IDLE;
         ptr                        <= '0;
         remain                     <= '0;
         csum                       <= '0;
         d_lo                       <= '0;
         bus.rx_ready               <= 1'b0;
         bus.instruction_wr1        <= '0;
         bus.instruction_wr1_data   <= '0;
         bus.instruction_wr1_enable <= 1'b0;
         bus.core_hold              <= 1'b0;
         bus.load_done              <= 1'b0;
         bus.load_error             <= 1'b0;
      end else begin
         bus.rx_ready               <= 1'b1;
         bus.instruction_wr1_enable <= 1'b0;
         bus.load_done              <= 1'b0;
         bus.load_error             <= 1'b0;
         if (acc) begin
            // Checksum covers every byte between SYNC and C.
            if (state != ST_IDLE && state != ST_CSUM) csum <= csum ^ d;
            unique case (state)
               ST_IDLE: if (d == SYNC_BYTE) begin
                  state         <= ST_ADDR0;
                  csum          <= '0;
                  bus.core_hold <= 1'b1;
               end
               ST_ADDR0: begin ptr[7:0]   <= d;      state <= ST_ADDR1; end
               ST_ADDR1: begin ptr[15:8]  <= d;      state <= ST_ADDR2; end
               ST_ADDR2: begin ptr[19:16] <= d[3:0]; state <= ST_LEN0;  end
               ST_LEN0:  begin remain[7:0] <= d;     state <= ST_LEN1;  end
               ST_LEN1: begin
                  remain[15:8] <= d;
                  state        <= ({d, remain[7:0]} == '0) ? ST_CSUM : ST_DATA_LO;
               end
               ST_DATA_LO: begin d_lo <= d; state <= ST_DATA_HI; end
               ST_DATA_HI: begin
                  bus.instruction_wr1        <= ptr;
                  bus.instruction_wr1_data   <= {d, d_lo};
                  bus.instruction_wr1_enable <= 1'b1;
                  ptr                        <= ptr + ADDR_W'(1);
                  remain                     <= remain - LEN_W'(1);
                  state <= (remain == LEN_W'(1)) ? ST_CSUM : ST_DATA_LO;
               end
               ST_CSUM: begin
                  bus.load_done  <= (d == csum);
                  bus.load_error <= (d != csum);
                  bus.core_hold  <= 1'b0;
                  state          <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end else if (expire) begin
            bus.load_error <= 1'b1;
            bus.core_hold  <= 1'b0;
            state          <= ST_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized frames against a frame-level reference model.
module tb_imem_loader;
   import imem_loader_pkg::*;

   localparam int TMO = 8;
   typedef logic [15:0] wq_t[$];

   logic clock = 1'b0;
   logic reset = 1'b0;
   imem_loader_if bus();

   imem_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT(TMO)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int n_chk = 0, n_fail = 0;
   int wr_seen = 0, done_seen = 0, err_seen = 0;

   always @(negedge clock) begin
      if (reset) begin
         if (bus.instruction_wr1_enable) wr_seen++;
         if (bus.load_done)              done_seen++;
         if (bus.load_error)             err_seen++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(posedge clock); #1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
   endtask

   task automatic idle(input int k);
      repeat (k) begin @(posedge clock); #1; end
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, " rx_ready"},  bus.rx_ready, 0);
      chk({tag, " wr_en"},     bus.instruction_wr1_enable, 0);
      chk({tag, " wr_addr"},   bus.instruction_wr1, 0);
      chk({tag, " wr_data"},   bus.instruction_wr1_data, 0);
      chk({tag, " core_hold"}, bus.core_hold, 0);
      chk({tag, " done"},      bus.load_done, 0);
      chk({tag, " error"},     bus.load_error, 0);
   endtask

   // Model: word i lands at (base mod 2^20 + i) mod 2^20; done iff C equals
   // the XOR of all header and data bytes.
   task automatic send_frame(input string tag, input logic [23:0] addr, input wq_t words,
                             input bit bad, input int gmin, input int gmax);
      logic [7:0]  hdr [5];
      logic [7:0]  c;
      logic [15:0] len;
      int          w0, d0, e0, exp_a;
      len    = 16'(words.size());
      hdr[0] = addr[7:0];  hdr[1] = addr[15:8]; hdr[2] = addr[23:16];
      hdr[3] = len[7:0];   hdr[4] = len[15:8];
      c = 8'h00;
      foreach (hdr[i])   c ^= hdr[i];
      foreach (words[i]) c ^= words[i][7:0] ^ words[i][15:8];
      if (bad) c = ~c;
      w0 = wr_seen; d0 = done_seen; e0 = err_seen;

      send_byte(8'hA5);
      @(negedge clock);
      chk({tag, " hold_after_sync"}, bus.core_hold, 1);
      foreach (hdr[i]) begin
         idle(int'($urandom_range(gmax, gmin)));
         send_byte(hdr[i]);
      end
      foreach (words[i]) begin
         idle(int'($urandom_range(gmax, gmin)));
         send_byte(words[i][7:0]);
         idle(int'($urandom_range(gmax, gmin)));
         send_byte(words[i][15:8]);
         @(negedge clock);
         exp_a = (int'(addr % 24'h100000) + i) % 32'h100000;
         chk({tag, " wr_en"},   bus.instruction_wr1_enable, 1);
         chk({tag, " wr_addr"}, bus.instruction_wr1, exp_a);
         chk({tag, " wr_data"}, bus.instruction_wr1_data, words[i]);
      end
      idle(int'($urandom_range(gmax, gmin)));
      chk({tag, " hold_before_csum"}, bus.core_hold, 1);
      send_byte(c);
      @(negedge clock);
      chk({tag, " hold_released"}, bus.core_hold, 0);
      chk({tag, " done_pulse"},    bus.load_done, !bad);
      chk({tag, " error_pulse"},   bus.load_error, bad);
      idle(3);
      chk({tag, " write_count"}, wr_seen - w0, words.size());
      chk({tag, " done_count"},  done_seen - d0, !bad);
      chk({tag, " error_count"}, err_seen - e0, bad);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      wq_t ws;
      int  k, d0, e0;
      bit  found, hold_at_err;

      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      #2;
      check_outputs_zero("reset");
      @(negedge clock); @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      chk("rx_ready_after_reset", bus.rx_ready, 1);

      send_frame("basic", 24'h000010, '{16'h1234, 16'h5678}, 1'b0, 0, 0);
      send_frame("wrap",  24'h0FFFFF, '{16'hBEEF, 16'hCAFE}, 1'b0, 0, 2);
      send_frame("badcs", 24'h000010, '{16'h1234, 16'h5678}, 1'b1, 0, 0);

      send_byte(8'h00);
      send_byte(8'hFF);
      send_frame("empty", 24'h000000, '{}, 1'b0, 0, 0);

      // Longest tolerated stall: byte lands on the terminal-count cycle.
      send_frame("gap_limit", 24'h000200, '{16'hA5A5}, 1'b0, TMO - 1, TMO - 1);

      // Timeout: count edges from the last accepted byte to the error pulse.
      d0 = done_seen; e0 = err_seen;
      send_byte(8'hA5);
      send_byte(8'h01);
      k = 0; found = 1'b0; hold_at_err = 1'b1;
      for (int i = 1; i <= 40 && !found; i++) begin
         @(posedge clock); @(negedge clock);
         if (bus.load_error) begin
            found = 1'b1; k = i; hold_at_err = bus.core_hold;
         end
      end
      chk("timeout_latency", k, TMO);
      chk("timeout_hold", hold_at_err, 0);
      idle(2);
      chk("timeout_err_count", err_seen - e0, 1);
      chk("timeout_done_count", done_seen - d0, 0);
      send_frame("after_tmo", 24'h000040, '{16'h0001, 16'h0002, 16'h0003}, 1'b0, 0, 1);

      for (int f = 0; f < 8; f++) begin
         ws = {};
         for (int j = 0; j < int'($urandom_range(5, 1)); j++) ws.push_back(16'($urandom));
         send_frame($sformatf("rand%0d", f), 24'($urandom), ws,
                    ($urandom_range(3, 0) == 0), 0, 3);
      end

      // Reset mid-frame, just after a D_lo byte.
      d0 = done_seen; e0 = err_seen;
      send_byte(8'hA5);
      send_byte(8'h23); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h11);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check_outputs_zero("midreset");
      idle(2);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      chk("midreset_rx_ready", bus.rx_ready, 1);
      chk("midreset_no_done", done_seen - d0, 0);
      chk("midreset_no_error", err_seen - e0, 0);
      send_frame("after_reset", 24'h000123, '{16'h1111, 16'h2222}, 1'b0, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
